// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the ALU-sharing arbiter: flag layout, FSM state encoding
// and the latency-counter width helper.
package alu_share_arb_pkg;

  localparam int FLAG_W      = 5;
  localparam int FLAG_SIGN   = 0;
  localparam int FLAG_ZERO   = 1;
  localparam int FLAG_CARRY  = 2;
  localparam int FLAG_PARITY = 3;
  localparam int FLAG_OVF    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Counter must hold ALU_LAT-1; never narrower than one bit.
  function automatic int cnt_width(input int lat);
    return (lat <= 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/alu_share_arb_rr_arbiter.sv
// Combinational round-robin arbiter: searches req from ptr+1 upward (wrapping) and
// returns a one-hot grant plus the encoded winner index.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  // cand[k] is the requester examined at priority k (0 = highest).
  logic [IW-1:0] cand [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    assign cand[gi] = IW'((int'(ptr) + gi + 1) % N);
  end

  always_comb begin
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[cand[k]]) begin
        grant[cand[k]] = 1'b1;
        idx            = cand[k];
        found          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin sequencer sharing one combinational ALU among N_REQ requesters.
// Optional ALU_ARB_STATS_EN adds a wrapping 16-bit completed-operation counter (op_count).
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 16,
  parameter int ALU_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*WIDTH-1:0]     req_x,
  input  logic [N_REQ*WIDTH-1:0]     req_y,
  output logic [WIDTH-1:0]           alu_x,
  output logic [WIDTH-1:0]           alu_y,
  input  logic [WIDTH-1:0]           alu_z,
  input  logic [FLAG_W-1:0]          alu_flags,
  output logic                       rsp_valid,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [WIDTH-1:0]           rsp_z,
  output logic [FLAG_W-1:0]          rsp_flags,
  output logic                       busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]                op_count
`endif
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = cnt_width(ALU_LAT);

  state_t             state_reg, state_next;
  logic [ID_W-1:0]    ptr_reg, ptr_next;
  logic [ID_W-1:0]    owner_reg, owner_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [WIDTH-1:0]   alu_x_reg, alu_x_next;
  logic [WIDTH-1:0]   alu_y_reg, alu_y_next;
  logic [WIDTH-1:0]   rsp_z_reg, rsp_z_next;
  logic [FLAG_W-1:0]  rsp_flags_reg, rsp_flags_next;

  logic [N_REQ-1:0]   grant;
  logic [ID_W-1:0]    win_idx;

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (grant),
    .idx   (win_idx)
  );

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    owner_next     = owner_reg;
    cnt_next       = cnt_reg;
    alu_x_next     = alu_x_reg;
    alu_y_next     = alu_y_reg;
    rsp_z_next     = rsp_z_reg;
    rsp_flags_next = rsp_flags_reg;
    req_ready      = '0;
    case (state_reg)
      ST_IDLE: begin
        // Grant is masked during reset so no transfer is advertised that will be dropped.
        if (!rst) begin
          req_ready = grant;
        end
        if (!rst && (|grant)) begin
          alu_x_next = req_x[win_idx*WIDTH +: WIDTH];
          alu_y_next = req_y[win_idx*WIDTH +: WIDTH];
          owner_next = win_idx;
          ptr_next   = win_idx;
          cnt_next   = CNT_W'(ALU_LAT - 1);
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_reg == '0) begin
          rsp_z_next     = alu_z;
          rsp_flags_next = alu_flags;
          state_next     = ST_RESP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= ID_W'(N_REQ - 1);
      owner_reg     <= '0;
      cnt_reg       <= '0;
      alu_x_reg     <= '0;
      alu_y_reg     <= '0;
      rsp_z_reg     <= '0;
      rsp_flags_reg <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      owner_reg     <= owner_next;
      cnt_reg       <= cnt_next;
      alu_x_reg     <= alu_x_next;
      alu_y_reg     <= alu_y_next;
      rsp_z_reg     <= rsp_z_next;
      rsp_flags_reg <= rsp_flags_next;
    end
  end

  assign alu_x     = alu_x_reg;
  assign alu_y     = alu_y_reg;
  assign rsp_valid = (state_reg == ST_RESP);
  assign rsp_id    = owner_reg;
  assign rsp_z     = rsp_z_reg;
  assign rsp_flags = rsp_flags_reg;
  assign busy      = (state_reg != ST_IDLE);

`ifdef ALU_ARB_STATS_EN
  logic [15:0] op_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_reg <= '0;
    end else if (state_reg == ST_RESP) begin
      op_count_reg <= op_count_reg + 16'd1;
    end
  end

  assign op_count = op_count_reg;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: ALU_LAT=1 instance for arbitration/flags/reset,
// ALU_LAT=3 instance for latency and (with ALU_ARB_STATS_EN) op_count.
module tb_alu_share_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid, req_ready;
  logic [63:0] req_x, req_y;
  logic [15:0] alu_x, alu_y, alu_z, rsp_z;
  logic [4:0]  alu_flags, rsp_flags;
  logic        rsp_valid, busy;
  logic [1:0]  rsp_id;

  logic [3:0]  r3_valid, r3_ready;
  logic [63:0] r3_x, r3_y;
  logic [15:0] a3_x, a3_y, a3_z, r3_z;
  logic [4:0]  a3_flags, r3_flags;
  logic        r3_rsp_valid, r3_busy;
  logic [1:0]  r3_id;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] op_count;
`endif

  int total = 0;
  int bad   = 0;

  alu_share_arb #(.N_REQ(4), .WIDTH(16), .ALU_LAT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .alu_x(alu_x), .alu_y(alu_y),
    .alu_z(alu_z), .alu_flags(alu_flags), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_z(rsp_z), .rsp_flags(rsp_flags), .busy(busy)
  );

  alu_share_arb #(.N_REQ(4), .WIDTH(16), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(r3_valid), .req_ready(r3_ready),
    .req_x(r3_x), .req_y(r3_y), .alu_x(a3_x), .alu_y(a3_y),
    .alu_z(a3_z), .alu_flags(a3_flags), .rsp_valid(r3_rsp_valid),
    .rsp_id(r3_id), .rsp_z(r3_z), .rsp_flags(r3_flags), .busy(r3_busy)
`ifdef ALU_ARB_STATS_EN
    , .op_count(op_count)
`endif
  );

  // Stand-in for the shared 16-bit ALU: {ovf,parity(even),carry,zero,sign}.
  function automatic logic [20:0] alu(input logic [15:0] x, input logic [15:0] y);
    logic [16:0] s;
    logic        ovf;
    s   = {1'b0, x} + {1'b0, y};
    ovf = (x[15] == y[15]) && (s[15] != x[15]);
    return {ovf, ~^s[15:0], s[16], (s[15:0] == 16'h0), s[15], s[15:0]};
  endfunction

  always_comb {alu_flags, alu_z} = alu(alu_x, alu_y);
  always_comb {a3_flags, a3_z}   = alu(a3_x, a3_y);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_op(input int i, input logic [15:0] x, input logic [15:0] y);
    req_x[i*16 +: 16] = x;
    req_y[i*16 +: 16] = y;
    r3_x[i*16 +: 16]  = x;
    r3_y[i*16 +: 16]  = y;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    r3_valid  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req_x = '0; req_y = '0; r3_x = '0; r3_y = '0;
    do_reset();
    #1;
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL rst_ready got=%b want=0000", req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b want=0", rsp_valid); end
    total++; if ({rsp_id, rsp_z, rsp_flags} !== 23'h0) begin bad++; $display("FAIL rst_rsp id=%h z=%h f=%b want 0", rsp_id, rsp_z, rsp_flags); end
    total++; if ({alu_x, alu_y} !== 32'h0) begin bad++; $display("FAIL rst_alu x=%h y=%h want 0", alu_x, alu_y); end
    $display("reset: ready=%b busy=%b rsp_valid=%b", req_ready, busy, rsp_valid);
  endtask

  task automatic test_single(input int id, input logic [15:0] x, input logic [15:0] y,
                             input logic [15:0] ez, input logic [4:0] ef, input string nm);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    set_op(id, x, y);
    req_valid = oh;
    #1;
    total++; if (req_ready !== oh) begin bad++; $display("FAIL %s_grant got=%b want=%b", nm, req_ready, oh); end
    @(negedge clk);
    total++; if ({alu_x, alu_y} !== {x, y}) begin bad++; $display("FAIL %s_operands got=%h/%h want=%h/%h", nm, alu_x, alu_y, x, y); end
    total++; if ({busy, rsp_valid, req_ready} !== 6'b100000) begin bad++; $display("FAIL %s_exec busy=%b rv=%b rdy=%b", nm, busy, rsp_valid, req_ready); end
    req_valid = '0;
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL %s_rsp_valid got=%b want=1", nm, rsp_valid); end
    total++; if (rsp_id !== 2'(id)) begin bad++; $display("FAIL %s_rsp_id got=%0d want=%0d", nm, rsp_id, id); end
    total++; if (rsp_z !== ez) begin bad++; $display("FAIL %s_z got=%h want=%h", nm, rsp_z, ez); end
    total++; if (rsp_flags !== ef) begin bad++; $display("FAIL %s_flags got=%b want=%b", nm, rsp_flags, ef); end
    $display("%s: id=%0d x=%h y=%h z=%h flags=%b", nm, rsp_id, x, y, rsp_z, rsp_flags);
    @(negedge clk);
    total++; if ({rsp_valid, busy} !== 2'b00 || rsp_z !== ez) begin bad++; $display("FAIL %s_after rv=%b busy=%b z=%h want 0/0/%h", nm, rsp_valid, busy, rsp_z, ez); end
  endtask

  task automatic test_round_robin();
    int e;
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 16'(i * 16'h1000 + 1), 16'h0001);
    req_valid = 4'hf;
    for (int g = 0; g < 5; g++) begin
      e = g % 4;
      #1;
      total++; if (req_ready !== (4'b0001 << e)) begin bad++; $display("FAIL rr_grant%0d got=%b want=%b", g, req_ready, 4'b0001 << e); end
      @(negedge clk);
      @(negedge clk);
      total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(e)) begin bad++; $display("FAIL rr_rsp%0d valid=%b id=%0d want 1/%0d", g, rsp_valid, rsp_id, e); end
      total++; if (rsp_z !== 16'(e * 16'h1000 + 2)) begin bad++; $display("FAIL rr_z%0d got=%h want=%h", g, rsp_z, 16'(e * 16'h1000 + 2)); end
      $display("rr: grant %0d -> id=%0d z=%h", g, rsp_id, rsp_z);
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_back_to_back();
    set_op(2, 16'haaaa, 16'h5555);
    req_valid = 4'b0100;
    for (int g = 0; g < 3; g++) begin
      #1;
      total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL b2b_grant%0d got=%b want=0100", g, req_ready); end
      @(negedge clk);
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL b2b_exec_ready%0d got=%b want=0000", g, req_ready); end
      @(negedge clk);
      total++; if ({rsp_valid, rsp_id} !== 3'b110) begin bad++; $display("FAIL b2b_rsp%0d valid=%b id=%0d want 1/2", g, rsp_valid, rsp_id); end
      total++; if ({rsp_z, rsp_flags} !== {16'hffff, 5'b01001}) begin bad++; $display("FAIL b2b_result%0d z=%h f=%b want ffff/01001", g, rsp_z, rsp_flags); end
      $display("b2b: op %0d id=%0d z=%h flags=%b", g, rsp_id, rsp_z, rsp_flags);
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_reset_abort();
    set_op(1, 16'h1234, 16'h1111);
    req_valid = 4'b0010;
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_exec busy=%b want=1", busy); end
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    total++; if ({rsp_valid, busy, req_ready} !== 6'b0) begin bad++; $display("FAIL abort_ctl rv=%b busy=%b rdy=%b want 0", rsp_valid, busy, req_ready); end
    total++; if ({alu_x, alu_y, rsp_z, rsp_flags, rsp_id} !== 55'h0) begin bad++; $display("FAIL abort_regs x=%h y=%h z=%h f=%b id=%0d want 0", alu_x, alu_y, rsp_z, rsp_flags, rsp_id); end
    rst = 1'b0;
    req_valid = 4'hf;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL abort_first_grant got=%b want=0001", req_ready); end
    req_valid = '0;
    @(negedge clk);
    total++; if ({rsp_valid, busy} !== 2'b00) begin bad++; $display("FAIL abort_idle1 rv=%b busy=%b want 0/0", rsp_valid, busy); end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL abort_idle2 rv=%b want 0", rsp_valid); end
    $display("abort: reset during EXEC, rsp_valid=%b rsp_z=%h", rsp_valid, rsp_z);
  endtask

  task automatic lat3_op(input int g);
    #1;
    total++; if (r3_ready !== 4'b0010) begin bad++; $display("FAIL lat3_grant%0d got=%b want=0010", g, r3_ready); end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      total++; if ({r3_busy, r3_rsp_valid} !== 2'b10) begin bad++; $display("FAIL lat3_wait%0d_%0d busy=%b rv=%b want 1/0", g, c, r3_busy, r3_rsp_valid); end
    end
    @(negedge clk);
    total++; if ({r3_rsp_valid, r3_id, r3_z, r3_flags} !== {1'b1, 2'd1, 16'h0003, 5'b01000}) begin bad++; $display("FAIL lat3_rsp%0d rv=%b id=%0d z=%h f=%b want 1/1/0003/01000", g, r3_rsp_valid, r3_id, r3_z, r3_flags); end
    $display("lat3: op %0d id=%0d z=%h flags=%b", g, r3_id, r3_z, r3_flags);
    @(negedge clk);
  endtask

  task automatic test_lat3_stats();
    do_reset();
    set_op(1, 16'h0001, 16'h0002);
    r3_valid = 4'b0010;
    for (int g = 0; g < 5; g++) lat3_op(g);
    r3_valid = '0;
`ifdef ALU_ARB_STATS_EN
    total++; if (op_count !== 16'd5) begin bad++; $display("FAIL stats_count got=%0d want=5", op_count); end
    force dut3.op_count_reg = 16'hfffe;
    #1;
    release dut3.op_count_reg;
    r3_valid = 4'b0010;
    lat3_op(5);
    total++; if (op_count !== 16'hffff) begin bad++; $display("FAIL stats_ffff got=%h want=ffff", op_count); end
    lat3_op(6);
    r3_valid = '0;
    total++; if (op_count !== 16'h0000) begin bad++; $display("FAIL stats_wrap got=%h want=0000", op_count); end
    $display("stats: op_count=%h after wrap", op_count);
`endif
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    r3_valid  = '0;
    test_reset();
    test_single(0, 16'h8fff, 16'h8000, 16'h0fff, 5'b11100, "t1");
    test_single(1, 16'hfffe, 16'h0002, 16'h0000, 5'b01110, "t2");
    test_round_robin();
    test_back_to_back();
    test_reset_abort();
    test_lat3_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
